// File: rtl/pc_unit_if.sv
// pc_unit_if: bundles the fetch-side control inputs and the PC/status outputs
// of pc_unit. The pipeline side (hazard unit, branch resolution, fetch) uses
// the master modport; pc_unit itself uses the slave modport.
interface pc_unit_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);
  // Control from the pipeline towards the PC unit
  logic             fetch_ready;
  logic             stall;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_target;
  logic             trap_valid;
  logic [XLEN-1:0]  trap_vector;
  logic             halt;
  logic             resume;

  // Status from the PC unit towards fetch and IF/ID
  logic [XLEN-1:0]  pc_out;
  logic             pc_valid;
  logic             misalign_fault;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    output fetch_ready, stall, redirect_valid, redirect_target,
           trap_valid, trap_vector, halt, resume,
    input  pc_out, pc_valid, misalign_fault, fetch_count
  );

  modport slave (
    input  fetch_ready, stall, redirect_valid, redirect_target,
           trap_valid, trap_vector, halt, resume,
    output pc_out, pc_valid, misalign_fault, fetch_count
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter for the head of the IF stage.
//   - BOOT / RUN / HALTED control FSM, pc_valid asserted only in RUN.
//   - Next-PC priority: trap > redirect > sequential accept > hold.
//   - Accept = pc_valid & fetch_ready & ~stall; accepted fetches are counted
//     in a free-running wrap-around counter.
//   - All outputs come straight from registers.
// Optional feature macro: PC_MISALIGN_TRAP_EN
//   defined   : a misaligned redirect loads trap_vector instead of the target
//               and misalign_fault pulses for one cycle.
//   undefined : the target's low alignment bits are cleared before loading and
//               misalign_fault is tied low.
module pc_unit #(
  parameter int          XLEN         = 64,
  parameter logic [63:0] RESET_VECTOR = 64'h0,
  parameter int          INST_BYTES   = 4,
  parameter int          CNT_W        = 32
) (
  input  logic     clk,
  input  logic     rst,
  pc_unit_if.slave bus
);

  // Sequential step and the mask selecting the instruction-alignment bits.
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);
  localparam logic [XLEN-1:0] RESET_PC   = RESET_VECTOR[XLEN-1:0];

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_pc_valid;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  w_pc_next;
  logic [XLEN-1:0]  w_redirect_pc;
  logic [CNT_W-1:0] r_fetch_count;
  logic             w_accept;
  logic             w_count_en;
  logic             w_pc_load;

  // A fetch is only handed over while the PC is valid and fetch can take it.
  assign w_accept = r_pc_valid & bus.fetch_ready & ~bus.stall;

  // ---------------------------------------------------------------------
  // Redirect target handling (alignment policy selected at build time)
  // ---------------------------------------------------------------------
`ifdef PC_MISALIGN_TRAP_EN
  logic w_misalign;
  logic r_misalign_fault;

  // A redirect is misaligned when any instruction-alignment bit is set.
  assign w_misalign = bus.redirect_valid & (|(bus.redirect_target & ALIGN_MASK));

  // Misaligned redirects divert to the trap handler instead of the target.
  always_comb begin
    w_redirect_pc = bus.redirect_target;
    if (w_misalign) begin
      w_redirect_pc = bus.trap_vector;
    end
  end

  // Fault flag is registered so it reads as a clean one-cycle pulse per event;
  // it fires even when a simultaneous trap masks the redirect itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign_fault <= 1'b0;
    end else begin
      r_misalign_fault <= w_misalign;
    end
  end

  assign bus.misalign_fault = r_misalign_fault;
`else
  // Misaligned redirects are silently rounded down to the instruction boundary.
  always_comb begin
    w_redirect_pc = bus.redirect_target & ~ALIGN_MASK;
  end

  assign bus.misalign_fault = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------

  // State register; pc_valid is registered from the next state so it has no
  // combinational path from any input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_BOOT;
      r_pc_valid <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc_valid <= (w_state_next == ST_RUN);
    end
  end

  // Next-state logic: BOOT lasts one cycle, halt beats resume.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_BOOT: begin
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (bus.halt) begin
          w_state_next = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (bus.resume && !bus.halt) begin
          w_state_next = ST_RUN;
        end
      end
      default: begin
        w_state_next = ST_BOOT;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Next-PC selection
  // ---------------------------------------------------------------------

  // Strict priority trap > redirect > sequential. Trap and redirect act in
  // every state; sequential advance only happens on an accept (RUN only).
  // A cycle that loads a trap or redirect target does not count as a fetch.
  always_comb begin
    w_pc_next  = r_pc;
    w_pc_load  = 1'b0;
    w_count_en = 1'b0;
    if (bus.trap_valid) begin
      w_pc_next = bus.trap_vector;
      w_pc_load = 1'b1;
    end else if (bus.redirect_valid) begin
      w_pc_next = w_redirect_pc;
      w_pc_load = 1'b1;
    end else if (w_accept) begin
      w_pc_next  = r_pc + PC_STEP;
      w_pc_load  = 1'b1;
      w_count_en = 1'b1;
    end
  end

  // PC register; the add above wraps naturally at 2^XLEN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (w_pc_load) begin
      r_pc <= w_pc_next;
    end
  end

  // Accepted-fetch counter, wraps at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_count <= '0;
    end else if (w_count_en) begin
      r_fetch_count <= r_fetch_count + 1'b1;
    end
  end

  assign bus.pc_out      = r_pc;
  assign bus.pc_valid    = r_pc_valid;
  assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenarios followed by random stimulus; every cycle the
// DUT outputs are compared with a behavioural model of the PC unit, and the
// directed scenarios also pin hand-computed literal values.
module tb_pc_unit;

  localparam int          XLEN  = 64;
  localparam int          CNT_W = 8;
  localparam int          IB    = 4;
  localparam logic [63:0] RV    = 64'h1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   check_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  pc_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  pc_unit #(
    .XLEN(XLEN), .RESET_VECTOR(RV), .INST_BYTES(IB), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;
  int               m_mode;
  logic [XLEN-1:0]  m_pc;
  logic [CNT_W-1:0] m_cnt;
  logic             m_fault;
  logic             m_acc;
  logic             m_mis;
  logic [XLEN-1:0]  m_redir;

  assign m_acc = (m_mode == M_RUN) && bus.fetch_ready && !bus.stall;
  assign m_mis = bus.redirect_valid && ((bus.redirect_target % IB) != 0);
`ifdef PC_MISALIGN_TRAP_EN
  assign m_redir = m_mis ? bus.trap_vector : bus.redirect_target;
`else
  assign m_redir = (bus.redirect_target / IB) * IB;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode  <= M_BOOT;
      m_pc    <= RV;
      m_cnt   <= '0;
      m_fault <= 1'b0;
    end else begin
`ifdef PC_MISALIGN_TRAP_EN
      m_fault <= m_mis;
`else
      m_fault <= 1'b0;
`endif
      if (bus.trap_valid)          m_pc <= bus.trap_vector;
      else if (bus.redirect_valid) m_pc <= m_redir;
      else if (m_acc)              m_pc <= m_pc + IB;
      if (m_acc && !bus.trap_valid && !bus.redirect_valid) m_cnt <= m_cnt + 1;
      if (m_mode == M_BOOT)                                m_mode <= M_RUN;
      else if (m_mode == M_RUN && bus.halt)                m_mode <= M_HALT;
      else if (m_mode == M_HALT && bus.resume && !bus.halt) m_mode <= M_RUN;
    end
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      cyc++;
      cmp("pc_out", bus.pc_out, m_pc);
      cmp("pc_valid", 64'(bus.pc_valid), 64'(m_mode == M_RUN));
      cmp("misalign_fault", 64'(bus.misalign_fault), 64'(m_fault));
      cmp("fetch_count", 64'(bus.fetch_count), 64'(m_cnt));
      $display("cyc %0d rst=%b pc=%h valid=%b fault=%b cnt=%0d", cyc, rst,
               bus.pc_out, bus.pc_valid, bus.misalign_fault, bus.fetch_count);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.trap_valid     = 1'b0;
    bus.halt           = 1'b0;
    bus.resume         = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    bus.fetch_ready     = 1'b0;
    bus.redirect_target = '0;
    bus.trap_vector     = '0;
    clear_ctl();
    check_en = 1'b1;
    tick();

    // Reset state
    cmp("rst_pc", bus.pc_out, 64'h1000);
    cmp("rst_valid", 64'(bus.pc_valid), 64'd0);
    cmp("rst_count", 64'(bus.fetch_count), 64'd0);
    cmp("rst_fault", 64'(bus.misalign_fault), 64'd0);

    // Boot then sequential fetch
    bus.fetch_ready = 1'b1;
    rst = 1'b0;
    cmp("boot_valid", 64'(bus.pc_valid), 64'd0);
    tick();
    cmp("run_valid", 64'(bus.pc_valid), 64'd1);
    cmp("run_pc0", bus.pc_out, 64'h1000);
    tick(); cmp("run_pc1", bus.pc_out, 64'h1004);
    tick(); cmp("run_pc2", bus.pc_out, 64'h1008);
    tick(); cmp("count3", 64'(bus.fetch_count), 64'd3);

    // Redirect to 0x2000, not counted
    bus.redirect_valid = 1'b1; bus.redirect_target = 64'h2000;
    tick(); clear_ctl();
    cmp("redir_pc", bus.pc_out, 64'h2000);
    cmp("redir_count", 64'(bus.fetch_count), 64'd3);

    // Stall holds, redirect overrides stall
    bus.stall = 1'b1;
    tick(); tick();
    cmp("stall_pc", bus.pc_out, 64'h2000);
    cmp("stall_count", 64'(bus.fetch_count), 64'd3);
    bus.redirect_valid = 1'b1; bus.redirect_target = 64'h3000;
    tick(); clear_ctl();
    cmp("stall_redir_pc", bus.pc_out, 64'h3000);

    // Trap beats redirect
    bus.trap_valid = 1'b1; bus.trap_vector = 64'h80;
    bus.redirect_valid = 1'b1; bus.redirect_target = 64'h400;
    tick(); clear_ctl();
    cmp("trap_pc", bus.pc_out, 64'h80);
    tick(); cmp("trap_next_pc", bus.pc_out, 64'h84);

    // PC wrap at 2^XLEN
    bus.redirect_valid = 1'b1; bus.redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick(); clear_ctl();
    tick(); cmp("pc_wrap", bus.pc_out, 64'h0);

    // Counter wrap at 2^CNT_W
    guard = 0;
    while (m_cnt != '1 && guard < 600) begin
      tick(); guard++;
    end
    cmp("cnt_reach_max", 64'(bus.fetch_count), 64'hFF);
    tick(); cmp("cnt_wrap", 64'(bus.fetch_count), 64'd0);

    // Misaligned redirect
    bus.trap_vector = 64'h7000;
    bus.redirect_valid = 1'b1; bus.redirect_target = 64'h1002;
    tick(); clear_ctl();
`ifdef PC_MISALIGN_TRAP_EN
    cmp("mis_pc", bus.pc_out, 64'h7000);
    cmp("mis_fault_on", 64'(bus.misalign_fault), 64'd1);
`else
    cmp("mis_pc", bus.pc_out, 64'h1000);
    cmp("mis_fault_on", 64'(bus.misalign_fault), 64'd0);
`endif
    tick(); cmp("mis_fault_off", 64'(bus.misalign_fault), 64'd0);

    // Halt with same-cycle accept, hold, resume
    bus.redirect_valid = 1'b1; bus.redirect_target = 64'h500;
    tick(); clear_ctl();
    cmp("halt_pre_pc", bus.pc_out, 64'h500);
    bus.halt = 1'b1;
    tick(); clear_ctl();
    cmp("halt_pc", bus.pc_out, 64'h504);
    for (int i = 0; i < 5; i++) begin
      tick();
      cmp("halt_valid", 64'(bus.pc_valid), 64'd0);
      cmp("halt_hold_pc", bus.pc_out, 64'h504);
    end
    bus.resume = 1'b1;
    tick(); clear_ctl();
    cmp("resume_valid", 64'(bus.pc_valid), 64'd1);
    cmp("resume_pc", bus.pc_out, 64'h504);

    // Asynchronous reset while halted
    bus.halt = 1'b1;
    tick(); clear_ctl();
    cmp("halt2_valid", 64'(bus.pc_valid), 64'd0);
    rst = 1'b1;
    #1;
    cmp("async_rst_pc", bus.pc_out, 64'h1000);
    cmp("async_rst_count", 64'(bus.fetch_count), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    cmp("reboot_valid", 64'(bus.pc_valid), 64'd1);

    // Random stimulus against the model
    for (int i = 0; i < 1500; i++) begin
      bus.fetch_ready    = ($urandom_range(0, 3) != 0);
      bus.stall          = ($urandom_range(0, 4) == 0);
      bus.redirect_valid = ($urandom_range(0, 9) == 0);
      bus.redirect_target = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) bus.redirect_target[1:0] = 2'b00;
      bus.trap_valid     = ($urandom_range(0, 19) == 0);
      bus.trap_vector    = {$urandom, $urandom} & ~64'h3;
      bus.halt           = ($urandom_range(0, 29) == 0);
      bus.resume         = ($urandom_range(0, 9) == 0);
      rst                = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    clear_ctl();
    tick();

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
